rete_totale_sequencer: RTL and testbench



---
 rtl/rete_totale_sequencer_if.sv | 23 ++
 rtl/rete_totale_sequencer.sv | 115 +++++++++++
 tb/tb_rete_totale_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rete_totale_sequencer_if.sv
// rtl/rete_totale_sequencer_if.sv - producer handshake plus Type A / Type B network signals
interface rete_totale_sequencer_if;
  logic        soc;
  logic [7:0]  x7_x0;
  logic        eoc;
  logic [3:0]  z3_z0;
  logic [3:0]  a_x3_x0;
  logic        a_b0;
  logic [7:0]  a_z7_z0;
  logic [15:0] b_x15_x0;
  logic [3:0]  b_z3_z0;

  // slave: the sequencer; master: producer together with the two combinational blocks
  modport slave (
    input  soc, x7_x0, a_z7_z0, b_z3_z0,
    output eoc, z3_z0, a_x3_x0, a_b0, b_x15_x0
  );

  modport master (
    output soc, x7_x0, a_z7_z0, b_z3_z0,
    input  eoc, z3_z0, a_x3_x0, a_b0, b_x15_x0
  );
endinterface

// File: rtl/rete_totale_sequencer.sv
// rtl/rete_totale_sequencer.sv - sequences one shared Type A block over two nibbles, then Type B
module rete_totale_sequencer #(
  parameter int unsigned A_SETTLE = 1,
  parameter int unsigned B_SETTLE = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  rete_totale_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_READY = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_EVAL  = 3'd3,
    ST_END   = 3'd4
  } star_t;

  localparam logic [3:0] A_LOAD = 4'(A_SETTLE - 1);
  localparam logic [3:0] B_LOAD = 4'(B_SETTLE - 1);

  star_t       star_q, star_d;
  logic [7:0]  x_q,    x_d;
  logic [15:0] w_q,    w_d;
  logic [3:0]  z_q,    z_d;
  logic        fb_q,   fb_d;
  logic [3:0]  cnt_q,  cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      star_q <= ST_READY;
      x_q    <= 8'h00;
      w_q    <= 16'h0000;
      z_q    <= 4'h0;
      fb_q   <= 1'b0;
      cnt_q  <= 4'h0;
    end else begin
      star_q <= star_d;
      x_q    <= x_d;
      w_q    <= w_d;
      z_q    <= z_d;
      fb_q   <= fb_d;
      cnt_q  <= cnt_d;
    end
  end

  // fb only moves at the EVAL exit, so both nibbles see the previous result's bit 0
  always_comb begin
    star_d = star_q;
    x_d    = x_q;
    w_d    = w_q;
    z_d    = z_q;
    fb_d   = fb_q;
    cnt_d  = cnt_q;
    case (star_q)
      ST_READY: begin
        if (bus.soc) begin
          x_d    = bus.x7_x0;
          cnt_d  = A_LOAD;
          star_d = ST_HI;
        end
      end
      ST_HI: begin
        if (cnt_q == 4'h0) begin
          w_d[15:8] = bus.a_z7_z0;
          cnt_d     = A_LOAD;
          star_d    = ST_LO;
        end else begin
          cnt_d = cnt_q - 4'h1;
        end
      end
      ST_LO: begin
        if (cnt_q == 4'h0) begin
          w_d[7:0] = bus.a_z7_z0;
          cnt_d    = B_LOAD;
          star_d   = ST_EVAL;
        end else begin
          cnt_d = cnt_q - 4'h1;
        end
      end
      ST_EVAL: begin
        if (cnt_q == 4'h0) begin
          z_d    = bus.b_z3_z0;
          fb_d   = bus.b_z3_z0[0];
          star_d = ST_END;
        end else begin
          cnt_d = cnt_q - 4'h1;
        end
      end
      ST_END: begin
        // soc must fall before another conversion can be accepted
        if (!bus.soc) begin
          star_d = ST_READY;
        end
      end
      default: begin
        star_d = ST_READY;
      end
    endcase
  end

  always_comb begin
    case (star_q)
      ST_HI:   bus.a_x3_x0 = x_q[7:4];
      ST_LO:   bus.a_x3_x0 = x_q[3:0];
      default: bus.a_x3_x0 = 4'h0;
    endcase
  end

  assign bus.eoc      = (star_q == ST_READY) || (star_q == ST_END);
  assign bus.z3_z0    = z_q;
  assign bus.b_x15_x0 = w_q;
  assign bus.a_b0     = fb_q;

endmodule

// File: tb/tb_rete_totale_sequencer.sv
// tb/tb_rete_totale_sequencer.sv - directed bench for rete_totale_sequencer
module tb_rete_totale_sequencer;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  rete_totale_sequencer_if bus1 ();
  rete_totale_sequencer_if bus2 ();

  // Type A stub z={x, x^{4{b0}}}; Type B stub z=x[15:12]^x[3:0]
  assign bus1.a_z7_z0 = {bus1.a_x3_x0, bus1.a_x3_x0 ^ {4{bus1.a_b0}}};
  assign bus1.b_z3_z0 = bus1.b_x15_x0[15:12] ^ bus1.b_x15_x0[3:0];
  assign bus2.a_z7_z0 = {bus2.a_x3_x0, bus2.a_x3_x0 ^ {4{bus2.a_b0}}};
  assign bus2.b_z3_z0 = bus2.b_x15_x0[15:12] ^ bus2.b_x15_x0[3:0];

  rete_totale_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  rete_totale_sequencer #(
    .A_SETTLE (3),
    .B_SETTLE (2)
  ) dut_slow (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic run_conv(input logic [7:0] x, output int lows);
    bus1.x7_x0 = x;
    bus1.soc   = 1'b1;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus1.eoc === 1'b0) lows++;
      else break;
    end
    bus1.soc = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    bus1.soc   = 1'b1;
    bus1.x7_x0 = 8'hA5;
    bus2.soc   = 1'b0;
    bus2.x7_x0 = 8'h00;
    repeat (2) @(negedge clock);
    checks++; if (bus1.eoc !== 1'b1) begin errors++; $display("FAIL reset_eoc got %b exp 1", bus1.eoc); end
    checks++; if (bus1.z3_z0 !== 4'h0) begin errors++; $display("FAIL reset_z got %h exp 0", bus1.z3_z0); end
    checks++; if (bus1.a_x3_x0 !== 4'h0) begin errors++; $display("FAIL reset_ax got %h exp 0", bus1.a_x3_x0); end
    checks++; if (bus1.a_b0 !== 1'b0) begin errors++; $display("FAIL reset_ab0 got %b exp 0", bus1.a_b0); end
    checks++; if (bus1.b_x15_x0 !== 16'h0000) begin errors++; $display("FAIL reset_bx got %h exp 0000", bus1.b_x15_x0); end
    reset    = 1'b0;
    bus1.soc = 1'b0;
    @(negedge clock);
    checks++; if (bus1.eoc !== 1'b1) begin errors++; $display("FAIL idle_eoc got %b exp 1", bus1.eoc); end
  endtask

  task automatic test_single;
    bus1.x7_x0 = 8'hA5;
    bus1.soc   = 1'b1;
    @(negedge clock);
    checks++; if (bus1.eoc !== 1'b0) begin errors++; $display("FAIL single_hi_eoc got %b exp 0", bus1.eoc); end
    checks++; if (bus1.a_x3_x0 !== 4'hA) begin errors++; $display("FAIL single_hi_ax got %h exp a", bus1.a_x3_x0); end
    checks++; if (bus1.a_b0 !== 1'b0) begin errors++; $display("FAIL single_ab0 got %b exp 0", bus1.a_b0); end
    bus1.x7_x0 = 8'h3C;
    @(negedge clock);
    checks++; if (bus1.a_x3_x0 !== 4'h5) begin errors++; $display("FAIL single_lo_ax got %h exp 5", bus1.a_x3_x0); end
    @(negedge clock);
    checks++; if (bus1.b_x15_x0 !== 16'hAA55) begin errors++; $display("FAIL single_bx got %h exp aa55", bus1.b_x15_x0); end
    checks++; if (bus1.eoc !== 1'b0) begin errors++; $display("FAIL single_eval_eoc got %b exp 0", bus1.eoc); end
    checks++; if (bus1.z3_z0 !== 4'h0) begin errors++; $display("FAIL single_z_hold got %h exp 0", bus1.z3_z0); end
    @(negedge clock);
    checks++; if (bus1.eoc !== 1'b1) begin errors++; $display("FAIL single_end_eoc got %b exp 1", bus1.eoc); end
    checks++; if (bus1.z3_z0 !== 4'hF) begin errors++; $display("FAIL single_z got %h exp f", bus1.z3_z0); end
    checks++; if (bus1.a_b0 !== 1'b1) begin errors++; $display("FAIL single_fb got %b exp 1", bus1.a_b0); end
    bus1.soc = 1'b0;
    @(negedge clock);
    checks++; if (bus1.eoc !== 1'b1) begin errors++; $display("FAIL single_ready_eoc got %b exp 1", bus1.eoc); end
  endtask

  task automatic test_feedback;
    bus1.x7_x0 = 8'hA5;
    bus1.soc   = 1'b1;
    @(negedge clock);
    checks++; if (bus1.a_b0 !== 1'b1) begin errors++; $display("FAIL fb_hi_ab0 got %b exp 1", bus1.a_b0); end
    @(negedge clock);
    checks++; if (bus1.a_b0 !== 1'b1) begin errors++; $display("FAIL fb_lo_ab0 got %b exp 1", bus1.a_b0); end
    @(negedge clock);
    checks++; if (bus1.b_x15_x0 !== 16'hA55A) begin errors++; $display("FAIL fb_bx got %h exp a55a", bus1.b_x15_x0); end
    @(negedge clock);
    checks++; if (bus1.z3_z0 !== 4'h0) begin errors++; $display("FAIL fb_z got %h exp 0", bus1.z3_z0); end
    bus1.soc = 1'b0;
    @(negedge clock);
    checks++; if (bus1.a_b0 !== 1'b0) begin errors++; $display("FAIL fb_return got %b exp 0", bus1.a_b0); end
  endtask

  task automatic test_handshake;
    int lows;
    bus1.x7_x0 = 8'hA5;
    bus1.soc   = 1'b1;
    lows = 0;
    repeat (14) begin
      @(negedge clock);
      if (bus1.eoc === 1'b0) lows++;
    end
    checks++; if (lows !== 3) begin errors++; $display("FAIL hs_low_cycles got %0d exp 3", lows); end
    checks++; if (bus1.eoc !== 1'b1) begin errors++; $display("FAIL hs_end_eoc got %b exp 1", bus1.eoc); end
    checks++; if (bus1.z3_z0 !== 4'hF) begin errors++; $display("FAIL hs_z got %h exp f", bus1.z3_z0); end
    bus1.soc = 1'b0;
    @(negedge clock);
    bus1.soc = 1'b1;
    @(negedge clock);
    checks++; if (bus1.eoc !== 1'b0) begin errors++; $display("FAIL hs_restart got %b exp 0", bus1.eoc); end
    lows = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus1.eoc === 1'b0) lows++;
      else break;
    end
    checks++; if (lows !== 3) begin errors++; $display("FAIL hs_second_low got %0d exp 3", lows); end
    checks++; if (bus1.z3_z0 !== 4'h0) begin errors++; $display("FAIL hs_second_z got %h exp 0", bus1.z3_z0); end
    bus1.soc = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid;
    int lows;
    run_conv(8'hA5, lows);
    checks++; if (bus1.z3_z0 !== 4'hF) begin errors++; $display("FAIL rm_pre_z got %h exp f", bus1.z3_z0); end
    bus1.x7_x0 = 8'hA5;
    bus1.soc   = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (bus1.a_x3_x0 !== 4'h5) begin errors++; $display("FAIL rm_in_lo got %h exp 5", bus1.a_x3_x0); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (bus1.eoc !== 1'b1) begin errors++; $display("FAIL rm_eoc got %b exp 1", bus1.eoc); end
    checks++; if (bus1.b_x15_x0 !== 16'h0000) begin errors++; $display("FAIL rm_bx got %h exp 0000", bus1.b_x15_x0); end
    checks++; if (bus1.z3_z0 !== 4'h0) begin errors++; $display("FAIL rm_z got %h exp 0", bus1.z3_z0); end
    checks++; if (bus1.a_b0 !== 1'b0) begin errors++; $display("FAIL rm_fb got %b exp 0", bus1.a_b0); end
    reset    = 1'b0;
    bus1.soc = 1'b0;
    @(negedge clock);
    run_conv(8'hA5, lows);
    checks++; if (lows !== 3) begin errors++; $display("FAIL rm_post_low got %0d exp 3", lows); end
    checks++; if (bus1.z3_z0 !== 4'hF) begin errors++; $display("FAIL rm_post_z got %h exp f", bus1.z3_z0); end
  endtask

  task automatic test_settle;
    int lows;
    int hi_cnt;
    int lo_cnt;
    int seq_bad;
    logic [3:0] exp_ax;
    bus2.x7_x0 = 8'hA5;
    bus2.soc   = 1'b1;
    lows = 0; hi_cnt = 0; lo_cnt = 0; seq_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus2.eoc !== 1'b0) break;
      exp_ax = (lows < 3) ? 4'hA : (lows < 6) ? 4'h5 : 4'h0;
      if (bus2.a_x3_x0 !== exp_ax) seq_bad++;
      if (bus2.a_x3_x0 === 4'hA) hi_cnt++;
      if (bus2.a_x3_x0 === 4'h5) lo_cnt++;
      lows++;
    end
    checks++; if (lows !== 8) begin errors++; $display("FAIL settle_low got %0d exp 8", lows); end
    checks++; if (hi_cnt !== 3) begin errors++; $display("FAIL settle_hi got %0d exp 3", hi_cnt); end
    checks++; if (lo_cnt !== 3) begin errors++; $display("FAIL settle_lo got %0d exp 3", lo_cnt); end
    checks++; if (seq_bad !== 0) begin errors++; $display("FAIL settle_order got %0d bad exp 0", seq_bad); end
    checks++; if (bus2.z3_z0 !== 4'hF) begin errors++; $display("FAIL settle_z got %h exp f", bus2.z3_z0); end
    checks++; if (bus2.b_x15_x0 !== 16'hAA55) begin errors++; $display("FAIL settle_bx got %h exp aa55", bus2.b_x15_x0); end
    bus2.soc = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_feedback();
    test_handshake();
    test_reset_mid();
    test_settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
